// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice blocks: key layout, default widths and
// the width helper used to size the mixer output.
package synth_pkg;

  localparam int unsigned KEY_W     = 7;
  localparam int unsigned OCT_W     = 3;
  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned DEF_AMP_W = 32;
  localparam int unsigned DEF_PER_W = 16;

  // Key layout: octave in bits [6:4], note in bits [3:0].
  typedef struct packed {
    logic [OCT_W-1:0]  octave;
    logic [NOTE_W-1:0] note;
  } key_t;

  // Ceiling log2, used for the number of guard bits in the mixer sum.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/poly_voice_controller_if.sv
// Event and audio bus between the key decoder, the voice controller and the
// effect chain.
interface poly_voice_controller_if #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AMP_W      = synth_pkg::DEF_AMP_W,
  parameter int unsigned PER_W      = synth_pkg::DEF_PER_W
);
  localparam int unsigned OUT_W = AMP_W + synth_pkg::clog2(NUM_VOICES);

  logic                    note_on;
  logic                    note_off;
  synth_pkg::key_t         key;
  logic [PER_W-1:0]        half_period;
  logic [AMP_W-2:0]        amplitude;
  logic signed [OUT_W-1:0] wave_out;
  logic [NUM_VOICES-1:0]   voice_active;
  logic                    stolen;

  modport master (
    output note_on, note_off, key, half_period, amplitude,
    input  wave_out, voice_active, stolen
  );

  modport slave (
    input  note_on, note_off, key, half_period, amplitude,
    output wave_out, voice_active, stolen
  );
endinterface

// File: rtl/voice_osc.sv
// One square-wave voice: holds its note parameters, counts out each half
// period and presents a signed sample (zero while idle).
module voice_osc
  import synth_pkg::*;
#(
  parameter int unsigned AMP_W = DEF_AMP_W,
  parameter int unsigned PER_W = DEF_PER_W,
  parameter int unsigned OUT_W = DEF_AMP_W + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    clear,
  input  key_t                    load_key,
  input  logic [PER_W-1:0]        load_period,
  input  logic [AMP_W-2:0]        load_amp,
  output logic                    active,
  output key_t                    voice_key,
  output logic signed [OUT_W-1:0] sample
);

  logic             active_q;
  key_t             key_q;
  logic [PER_W-1:0] period_q;
  logic [AMP_W-2:0] amp_q;
  logic [PER_W-1:0] cnt_q;
  logic             phase_q;

  logic signed [OUT_W-1:0] amp_ext;

  // Voice state: load restarts the positive half, clear parks the voice idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      key_q    <= '0;
      period_q <= '0;
      amp_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else if (load) begin
      active_q <= 1'b1;
      key_q    <= load_key;
      period_q <= load_period;
      amp_q    <= load_amp;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else if (clear) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == period_q - PER_W'(1)) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + PER_W'(1);
      end
    end
  end

  assign amp_ext = {{(OUT_W - AMP_W + 1){1'b0}}, amp_q};

  // Signed sample, already extended to the mixer width.
  always_comb begin
    sample = '0;
    if (active_q) begin
      sample = phase_q ? amp_ext : -amp_ext;
    end
  end

  assign active    = active_q;
  assign voice_key = key_q;

endmodule

// File: rtl/poly_voice_controller.sv
// Polyphonic square-wave controller: allocates note events to voices
// (retrigger, first free, round-robin steal) and registers the mixed output.
module poly_voice_controller
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AMP_W      = DEF_AMP_W,
  parameter int unsigned PER_W      = DEF_PER_W
) (
  input logic                   clk,
  input logic                   reset,
  poly_voice_controller_if.slave bus
);

  localparam int unsigned IDX_W = clog2(NUM_VOICES);
  localparam int unsigned OUT_W = AMP_W + IDX_W;

  logic [NUM_VOICES-1:0]   active;
  logic [NUM_VOICES-1:0]   match;
  logic [NUM_VOICES-1:0]   load;
  logic [NUM_VOICES-1:0]   clear;
  key_t                    voice_key [NUM_VOICES];
  logic signed [OUT_W-1:0] sample [NUM_VOICES];

  logic [IDX_W-1:0]        steal_ptr_q, steal_ptr_d;
  logic                    stolen_q, stolen_d;
  logic                    found;
  logic signed [OUT_W-1:0] mix_sum, wave_q;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_osc #(
      .AMP_W(AMP_W),
      .PER_W(PER_W),
      .OUT_W(OUT_W)
    ) u_voice (
      .clk        (clk),
      .reset      (reset),
      .load       (load[i]),
      .clear      (clear[i]),
      .load_key   (bus.key),
      .load_period(bus.half_period),
      .load_amp   (bus.amplitude),
      .active     (active[i]),
      .voice_key  (voice_key[i]),
      .sample     (sample[i])
    );
  end

  // Busy voices currently holding the event's key.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      match[i] = active[i] && (voice_key[i] == bus.key);
    end
  end

  // Allocation: retrigger beats free slot beats stealing; note_off only when
  // no note_on is present in the same cycle.
  always_comb begin
    load        = '0;
    clear       = '0;
    found       = 1'b0;
    stolen_d    = 1'b0;
    steal_ptr_d = steal_ptr_q;
    if (bus.note_on) begin
      if (bus.half_period != '0) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (!found && match[i]) begin
            load[i] = 1'b1;
            found   = 1'b1;
          end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (!found && !active[i]) begin
            load[i] = 1'b1;
            found   = 1'b1;
          end
        end
        if (!found) begin
          load[steal_ptr_q] = 1'b1;
          stolen_d          = 1'b1;
          steal_ptr_d       = steal_ptr_q + IDX_W'(1);
        end
      end
    end else if (bus.note_off) begin
      clear = match;
    end
  end

  // Mixer: guard bits in OUT_W make overflow impossible.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_sum = mix_sum + sample[i];
    end
  end

  // Steal pointer, steal pulse and registered mix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      steal_ptr_q <= '0;
      stolen_q    <= 1'b0;
      wave_q      <= '0;
    end else begin
      steal_ptr_q <= steal_ptr_d;
      stolen_q    <= stolen_d;
      wave_q      <= mix_sum;
    end
  end

  assign bus.wave_out     = wave_q;
  assign bus.voice_active = active;
  assign bus.stolen       = stolen_q;

endmodule

// File: tb/tb_poly_voice_controller.sv
// Scoreboard bench: the driver applies events, a rule-level voice model
// predicts each following cycle's outputs, and a monitor compares them.
module tb_poly_voice_controller;

  localparam int NV = 4;

  typedef struct {
    longint     wave;
    logic [3:0] act;
    logic       stl;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  poly_voice_controller_if #(.NUM_VOICES(NV), .AMP_W(32), .PER_W(16)) bus ();

  poly_voice_controller #(.NUM_VOICES(NV), .AMP_W(32), .PER_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  bit   mon_en = 1'b0;

  // Reference model: each voice remembers when it was (re)started; its sign is
  // derived from elapsed edges divided by the half period.
  bit                         m_act [NV];
  logic [synth_pkg::KEY_W-1:0] m_key [NV];
  longint                     m_per [NV];
  longint                     m_amp [NV];
  longint                     m_start [NV];
  int                         m_ptr;
  longint                     cur;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 1'b0;
      m_key[i] = '0;
      m_per[i] = 1;
      m_amp[i] = 0;
      m_start[i] = 0;
    end
    m_ptr = 0;
    cur = 0;
  endfunction

  function automatic longint model_wave();
    longint s = 0;
    for (int i = 0; i < NV; i++) begin
      if (m_act[i]) begin
        if (((cur - m_start[i]) / m_per[i]) % 2 == 0) s += m_amp[i];
        else s -= m_amp[i];
      end
    end
    return s;
  endfunction

  // Drive one cycle's inputs (called just after a falling edge) and queue the
  // outputs expected after the coming rising edge.
  task automatic drive(input bit on, input bit off, input logic [synth_pkg::KEY_W-1:0] k,
                       input int unsigned hp, input longint amp);
    exp_t e;
    int   idx;
    bus.note_on     = on;
    bus.note_off    = off;
    bus.key         = k;
    bus.half_period = 16'(hp);
    bus.amplitude   = 31'(amp);
    e.wave = model_wave();
    e.stl  = 1'b0;
    if (on) begin
      if (hp != 0) begin
        idx = -1;
        for (int i = 0; i < NV; i++) if (idx < 0 && m_act[i] && m_key[i] == k) idx = i;
        for (int i = 0; i < NV; i++) if (idx < 0 && !m_act[i]) idx = i;
        if (idx < 0) begin
          idx = m_ptr;
          m_ptr = (m_ptr + 1) % NV;
          e.stl = 1'b1;
        end
        m_act[idx] = 1'b1;
        m_key[idx] = k;
        m_per[idx] = longint'(hp);
        m_amp[idx] = amp;
        m_start[idx] = cur + 1;
      end
    end else if (off) begin
      for (int i = 0; i < NV; i++) if (m_act[i] && m_key[i] == k) m_act[i] = 1'b0;
    end
    cur++;
    for (int i = 0; i < NV; i++) e.act[i] = m_act[i];
    sb.push_back(e);
  endtask

  task automatic step(input bit on, input bit off, input logic [synth_pkg::KEY_W-1:0] k,
                      input int unsigned hp, input longint amp);
    @(negedge clk);
    drive(on, off, k, hp, amp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'h00, 0, 0);
  endtask

  // Monitor: one expected entry per rising edge while enabled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL sb_underflow: no expected entry at t=%0t", $time);
        end else begin
          e = sb.pop_front();
          check("wave_out", longint'(bus.wave_out), e.wave);
          check("voice_active", longint'(bus.voice_active), longint'(e.act));
          check("stolen", longint'(bus.stolen), longint'(e.stl));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.note_on = 1'b0;
    bus.note_off = 1'b0;
    bus.key = '0;
    bus.half_period = '0;
    bus.amplitude = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wave", longint'(bus.wave_out), 0);
    check("rst_active", longint'(bus.voice_active), 0);
    check("rst_stolen", longint'(bus.stolen), 0);

    // Release reset on a falling edge and start predicting immediately.
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 7'h00, 0, 0);

    // Single note, half period 3.
    step(1'b1, 1'b0, 7'h45, 3, 100);
    idle(13);
    step(1'b0, 1'b1, 7'h45, 0, 0);
    idle(3);

    // Two notes, periods 2 and 4.
    step(1'b1, 1'b0, 7'h10, 2, 50);
    step(1'b1, 1'b0, 7'h11, 4, 50);
    idle(16);

    // Fill all voices, then steal voice 0 and voice 1.
    step(1'b1, 1'b0, 7'h20, 5, 10);
    step(1'b1, 1'b0, 7'h21, 3, 20);
    idle(2);
    step(1'b1, 1'b0, 7'h22, 2, 30);
    idle(2);
    step(1'b1, 1'b0, 7'h23, 4, 40);
    idle(3);

    // Retrigger active key with a new amplitude, then release it.
    step(1'b1, 1'b0, 7'h21, 3, 7000);
    idle(5);
    step(1'b0, 1'b1, 7'h21, 0, 0);
    idle(3);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 7'(8'h20 + k), 0, 0);
    idle(2);

    // Simultaneous on/off, then a zero half period.
    step(1'b1, 1'b1, 7'h33, 2, 500);
    idle(3);
    step(1'b1, 1'b0, 7'h34, 0, 900);
    idle(3);
    step(1'b0, 1'b1, 7'h33, 0, 0);
    idle(2);

    // Extremes: full-scale amplitude on every voice, period 1.
    for (int k = 0; k < NV; k++) step(1'b1, 1'b0, 7'(8'h50 + k), 1, 64'h7fff_ffff);
    idle(6);

    // Asynchronous reset between edges with notes still sounding.
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("async_wave", longint'(bus.wave_out), 0);
    check("async_active", longint'(bus.voice_active), 0);
    check("async_stolen", longint'(bus.stolen), 0);
    bus.note_on = 1'b0;
    bus.note_off = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 7'h00, 0, 0);

    // Random traffic over a small key set to exercise retrigger/off/steal.
    for (int n = 0; n < 400; n++) begin
      int unsigned r = $urandom_range(0, 99);
      logic [6:0]  k = 7'($urandom_range(0, 7));
      int unsigned hp = $urandom_range(0, 5);
      longint      a = longint'($urandom() & 32'h7fff_ffff);
      if (r < 40) step(1'b1, 1'b0, k, hp, a);
      else if (r < 65) step(1'b0, 1'b1, k, 0, 0);
      else if (r < 70) step(1'b1, 1'b1, k, hp, a);
      else step(1'b0, 1'b0, k, hp, a);
    end
    idle(4);

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    check("sb_drain", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
